// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pwm_pkg
// Description : Shared constants and FSM encoding for the PWM generator/capture.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : pwm_edge_sync
// Description : Synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN)
//               and rise/fall detector for the PWM input pin.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_edge_sync
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int c_FLEN       = (FILTER_LEN < 1) ? 1 : FILTER_LEN;
    localparam int c_FCNT_W     = $clog2(c_FLEN + 1);
    localparam int c_FILT_DELAY = c_FLEN;
`else
    localparam int c_FILT_DELAY = 0 * FILTER_LEN;
`endif
    // Edges are masked until every stage behind the detector holds a real pin sample
    localparam int c_WARM   = c_STAGES + c_FILT_DELAY + 1;
    localparam int c_WARM_W = $clog2(c_WARM + 1);

    logic [c_STAGES-1:0] r_sync;
    logic                w_sync_out;
    logic                w_level;
    logic                r_level_d;
    logic [c_WARM_W-1:0] r_warm;
    logic                w_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_STAGES-2:0], pwm_in};
        end
    end

    assign w_sync_out = r_sync[c_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    logic                r_filt;
    logic [c_FCNT_W-1:0] r_fcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_sync_out != r_filt) begin
            if (r_fcnt == c_FCNT_W'(c_FLEN - 1)) begin
                r_filt <= w_sync_out;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + c_FCNT_W'(1);
            end
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
            r_warm    <= '0;
        end else begin
            r_level_d <= w_level;
            if (!w_armed) begin
                r_warm <= r_warm + c_WARM_W'(1);
            end
        end
    end

    assign w_armed = (r_warm == c_WARM_W'(c_WARM));
    assign s       = w_level;
    assign rise    = w_armed &  w_level & ~r_level_d;
    assign fall    = w_armed & ~w_level &  r_level_d;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures period and high time of a PWM input in clk cycles and
//               publishes them through a valid/ready holding register.
//               Optional glitch filter enabled by PWM_CAPTURE_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = c_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] meas_period,
    output logic [WIDTH-1:0] meas_high,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             signal_lost
);

    pwm_state_t       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_lat;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_cnt_max;
    logic             w_rise;
    logic             w_fall;
    logic             w_level_unused;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s      (w_level_unused),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // Saturating so a fall on the last count cannot wrap into a short period
    assign w_cnt_max  = &r_cnt;
    assign w_cnt_next = w_cnt_max ? r_cnt : r_cnt + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hi_lat    <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            overrun <= 1'b0;
            if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_cnt       <= WIDTH'(1);
                        signal_lost <= 1'b0;
                        r_state     <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        r_hi_lat <= r_cnt;
                        r_cnt    <= w_cnt_next;
                        r_state  <= LOW;
                    end else if (w_cnt_max) begin
                        signal_lost <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        meas_period <= r_cnt;
                        meas_high   <= r_hi_lat;
                        meas_valid  <= 1'b1;
                        overrun     <= meas_valid && !meas_ready;
                        r_cnt       <= WIDTH'(1);
                        r_state     <= HIGH;
                    end else if (w_cnt_max) begin
                        signal_lost <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture (16-bit and 8-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int c_SYNC = 2;
    localparam int c_FILT = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int c_LAT = c_SYNC + 1 + c_FILT;
`else
    localparam int c_LAT = c_SYNC + 1;
`endif

    typedef struct {
        int unsigned period;
        int unsigned high;
    } meas_t;

    typedef struct {
        int h;
        int p;
        int unsigned exp_high;
        int unsigned exp_period;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm16 = 1'b0;
    logic        rdy16 = 1'b1;
    logic [15:0] per16, hi16;
    logic        val16, ovr16, lost16;
    logic        pwm8 = 1'b0;
    logic        rdy8 = 1'b1;
    logic [7:0]  per8, hi8;
    logic        val8, ovr8, lost8;

    always #5 clk = ~clk;

    pwm_capture #(.WIDTH(16), .SYNC_STAGES(c_SYNC), .FILTER_LEN(c_FILT)) dut16 (
        .clk(clk), .rst(rst), .pwm_in(pwm16),
        .meas_period(per16), .meas_high(hi16), .meas_valid(val16),
        .meas_ready(rdy16), .overrun(ovr16), .signal_lost(lost16)
    );

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(c_SYNC), .FILTER_LEN(c_FILT)) dut8 (
        .clk(clk), .rst(rst), .pwm_in(pwm8),
        .meas_period(per8), .meas_high(hi8), .meas_valid(val8),
        .meas_ready(rdy8), .overrun(ovr8), .signal_lost(lost8)
    );

    meas_t got16[$];
    meas_t got8[$];
    meas_t exp16[$];
    meas_t m16, m8;
    int    ovr16_cnt  = 0;
    int    ovr16_wide = 0;
    int    ovr8_cnt   = 0;
    logic  ovr16_prev = 1'b0;
    int    checks = 0;
    int    errors = 0;

    // Consumer-side monitor: records every completed transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (val16 && rdy16) begin
                m16.period = per16;
                m16.high   = hi16;
                got16.push_back(m16);
            end
            if (val8 && rdy8) begin
                m8.period = per8;
                m8.high   = hi8;
                got8.push_back(m8);
            end
            if (ovr16) ovr16_cnt++;
            if (ovr16 && ovr16_prev) ovr16_wide++;
            if (ovr8) ovr8_cnt++;
        end
        ovr16_prev = ovr16;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic meas_t mk(input int unsigned p, input int unsigned h);
        meas_t m;
        m.period = p;
        m.high   = h;
        return m;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pin(input bit sel8, input logic v);
        if (sel8) pwm8 = v;
        else      pwm16 = v;
    endtask

    task automatic pulse(input bit sel8, input int h, input int p);
        set_pin(sel8, 1'b1);
        tick(h);
        set_pin(sel8, 1'b0);
        tick(p - h);
    endtask

    task automatic final_rise(input bit sel8);
        set_pin(sel8, 1'b1);
        tick(c_LAT + 2);
        set_pin(sel8, 1'b0);
        tick(5);
    endtask

    task automatic do_reset(input logic lvl, input string name);
        pwm16 = lvl;
        pwm8  = 1'b0;
        rst   = 1'b1;
        tick(3);
        check({name, "_valid"},  val16, 0);
        check({name, "_overrun"}, ovr16, 0);
        check({name, "_lost"},   lost16, 1);
        check({name, "_period"}, per16, 0);
        check({name, "_high"},   hi16, 0);
        rst = 1'b0;
    endtask

    task automatic check_stream(input string name, input int start);
        check({name, "_count"}, got16.size() - start, exp16.size());
        for (int i = 0; i < exp16.size(); i++) begin
            if (start + i < got16.size()) begin
                check($sformatf("%s_%0d_period", name, i), got16[start+i].period, exp16[i].period);
                check($sformatf("%s_%0d_high", name, i),   got16[start+i].high,   exp16[i].high);
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   start, ovr0, wide0, lat, n, p, h;

        // ---------------- reset state ----------------
        do_reset(1'b0, "reset");
        check("reset_valid8", val8, 0);
        check("reset_lost8", lost8, 1);
        tick(10);

        // ---------------- 100/25 stream, publish latency ----------------
        rdy16 = 1'b1;
        start = got16.size();
        ovr0  = ovr16_cnt;
        pulse(0, 25, 100);
        pwm16 = 1'b1;
        lat = 0;
        while (!val16 && lat < 40) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, c_LAT);
        tick(25 - lat);
        pwm16 = 1'b0;
        tick(75);
        pulse(0, 25, 100);
        pulse(0, 25, 100);
        final_rise(0);
        exp16.delete();
        repeat (4) exp16.push_back(mk(100, 25));
        check_stream("t1", start);
        check("t1_no_overrun", ovr16_cnt - ovr0, 0);

        // ---------------- reset during high pulse ----------------
        do_reset(1'b1, "t2_reset");
        tick(10);
        pwm16 = 1'b0;
        tick(60);
        check("t2_lost_before_rise", lost16, 1);
        start = got16.size();
        pulse(0, 25, 100);
        check("t2_lost_after_rise", lost16, 0);
        pulse(0, 25, 100);
        final_rise(0);
        exp16.delete();
        repeat (2) exp16.push_back(mk(100, 25));
        check_stream("t2", start);

        // ---------------- 8-bit timeout ----------------
        do_reset(1'b0, "t3_reset");
        tick(10);
        start = got8.size();
        pulse(1, 25, 100);
        pwm8 = 1'b1;
        n = 0;
        while (!lost8 && n < 400) begin
            tick();
            n++;
        end
        check("t3_timeout_cycles", n, c_LAT + 255);
        check("t3_lost_set", lost8, 1);
        check("t3_publish_count", got8.size() - start, 1);
        if (got8.size() > start) begin
            check("t3_period", got8[start].period, 100);
            check("t3_high", got8[start].high, 25);
        end
        tick(20);
        check("t3_no_late_publish", got8.size() - start, 1);
        pwm8 = 1'b0;
        tick(30);
        pwm8 = 1'b1;
        tick(c_LAT + 1);
        check("t3_lost_cleared", lost8, 0);
        tick(25 - c_LAT - 1);
        pwm8 = 1'b0;
        tick(75);
        final_rise(1);
        check("t3_resume_count", got8.size() - start, 2);
        if (got8.size() > start + 1) begin
            check("t3_resume_period", got8[start+1].period, 100);
            check("t3_resume_high", got8[start+1].high, 25);
        end
        check("t3_no_overrun8", ovr8_cnt, 0);

        // ---------------- overrun while not ready ----------------
        do_reset(1'b0, "t4_reset");
        tick(10);
        rdy16 = 1'b0;
        start = got16.size();
        ovr0  = ovr16_cnt;
        wide0 = ovr16_wide;
        pulse(0, 25, 100);
        pulse(0, 40, 80);
        final_rise(0);
        check("t4_overrun_pulses", ovr16_cnt - ovr0, 1);
        check("t4_overrun_width", ovr16_wide - wide0, 0);
        check("t4_valid_held", val16, 1);
        check("t4_period", per16, 80);
        check("t4_high", hi16, 40);
        check("t4_no_transfer", got16.size() - start, 0);
        rdy16 = 1'b1;
        tick();
        check("t4_transfer_count", got16.size() - start, 1);
        if (got16.size() > start) begin
            check("t4_xfer_period", got16[start].period, 80);
            check("t4_xfer_high", got16[start].high, 40);
        end
        check("t4_valid_cleared", val16, 0);

        // ---------------- ready on the publish cycle ----------------
        do_reset(1'b0, "t5_reset");
        tick(10);
        rdy16 = 1'b0;
        start = got16.size();
        ovr0  = ovr16_cnt;
        pulse(0, 25, 100);
        pulse(0, 20, 60);
        pwm16 = 1'b1;
        tick(c_LAT - 1);
        rdy16 = 1'b1;
        tick();
        rdy16 = 1'b0;
        check("t5_valid_kept", val16, 1);
        check("t5_period", per16, 60);
        check("t5_high", hi16, 20);
        check("t5_no_overrun", ovr16_cnt - ovr0, 0);
        check("t5_transfer_count", got16.size() - start, 1);
        if (got16.size() > start) begin
            check("t5_xfer_period", got16[start].period, 100);
            check("t5_xfer_high", got16[start].high, 25);
        end
        tick(10);
        pwm16 = 1'b0;
        tick(10);

        // ---------------- glitch inside a 25-cycle high pulse ----------------
        do_reset(1'b0, "t6_reset");
        tick(10);
        rdy16 = 1'b1;
        start = got16.size();
        pwm16 = 1'b1; tick(10);
        pwm16 = 1'b0; tick(2);
        pwm16 = 1'b1; tick(13);
        pwm16 = 1'b0; tick(75);
        pulse(0, 25, 100);
        final_rise(0);
        exp16.delete();
`ifdef PWM_CAPTURE_FILTER_EN
        exp16.push_back(mk(100, 25));
        exp16.push_back(mk(100, 25));
`else
        exp16.push_back(mk(12, 10));
        exp16.push_back(mk(88, 13));
        exp16.push_back(mk(100, 25));
`endif
        check_stream("t6", start);

        // ---------------- table-driven pulse trains ----------------
        vecs.push_back('{25, 100, 25, 100});
        vecs.push_back('{5, 10, 5, 10});
        vecs.push_back('{50, 55, 50, 55});
        vecs.push_back('{5, 300, 5, 300});
        vecs.push_back('{295, 300, 295, 300});
        vecs.push_back('{1000, 2000, 1000, 2000});
`ifndef PWM_CAPTURE_FILTER_EN
        vecs.push_back('{1, 2, 1, 2});
        vecs.push_back('{2, 3, 2, 3});
        vecs.push_back('{1, 3, 1, 3});
`endif
        do_reset(1'b0, "tab_reset");
        tick(10);
        start = got16.size();
        ovr0  = ovr16_cnt;
        exp16.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            pulse(0, vecs[i].h, vecs[i].p);
            exp16.push_back(mk(vecs[i].exp_period, vecs[i].exp_high));
        end
        final_rise(0);
        check_stream("tab", start);
        check("tab_no_overrun", ovr16_cnt - ovr0, 0);

        // ---------------- random pulse trains vs reference ----------------
        do_reset(1'b0, "rnd_reset");
        tick(10);
        start = got16.size();
        ovr0  = ovr16_cnt;
        exp16.delete();
        for (int k = 0; k < 25; k++) begin
            p = $urandom_range(400, 10);
            h = $urandom_range(p - 5, 5);
            exp16.push_back(mk(p, h));
            pulse(0, h, p);
        end
        final_rise(0);
        check_stream("rnd", start);
        check("rnd_no_overrun", ovr16_cnt - ovr0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
